// File: rtl/bits_imem_reader.sv
// bits_imem_reader: serves 16-byte instruction fetches for the bits core out
// of a 32-bit-wide instruction memory. Each request reads up to four words,
// packs them big-endian into a 128-bit word, masks bytes beyond the packet
// length and returns them with a one-cycle active-low acknowledge.
module bits_imem_reader (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  expectedBytes,
    input  logic         mem_req_b,
    output logic         mem_ack_b,
    output logic [127:0] instruction_word,
    output logic [15:0]  instruction_byte_valid,
    output logic         done_reading_memory,
    output logic         imem_ceb,
    output logic [13:0]  imem_addr,
    input  logic [31:0]  imem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_REQ,
        READ,
        ACK,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [15:0] remaining;      // packet bytes not yet acknowledged
    logic [13:0] base_addr;      // word address of the current fetch
    logic [4:0]  cnt;            // bytes delivered by the current fetch (1..16)
    logic [2:0]  n_reads;        // words read by the current fetch (1..4)
    logic [2:0]  rd_idx;         // reads issued so far in the current fetch
    logic        cap_pending;    // a read was issued last cycle; its data is on imem_rdata
    logic [1:0]  cap_lane;       // lane that pending data belongs to
    logic [15:0] fetch_mask;     // byte-valid mask of the current fetch, bit 15 = byte 0

    logic [4:0]  req_cnt;
    logic [4:0]  req_sum;
    logic [2:0]  req_n;
    logic        issue;
    logic        last_capture;
    logic [15:0] remaining_after;
    logic [6:0]  lane_hi;
    logic [3:0]  mask_hi;
    logic [3:0]  lane_bytes;
    logic [31:0] cap_data;

    // Per-request sizing, read issue and capture-lane masking.
    always_comb begin
        req_cnt         = (remaining >= 16'd16) ? 5'd16 : remaining[4:0];
        req_sum         = req_cnt + 5'd3;
        req_n           = req_sum[4:2];
        issue           = (state == READ) && (rd_idx < n_reads);
        last_capture    = (state == READ) && (rd_idx == n_reads);
        remaining_after = remaining - {11'b0, cnt};
        lane_hi         = 7'd127 - {cap_lane, 5'b0};
        mask_hi         = 4'd15 - {cap_lane, 2'b0};
        lane_bytes      = fetch_mask[mask_hi -: 4];
        cap_data        = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            cap_data[31 - 8*i -: 8] = imem_rdata[31 - 8*i -: 8] & {8{lane_bytes[3 - i]}};
        end
    end

    // Next-state logic; start overrides everything except reset.
    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = (expectedBytes == '0) ? DONE : WAIT_REQ;
        end else begin
            case (state)
                IDLE:     state_nx = IDLE;
                WAIT_REQ: if (!mem_req_b) state_nx = READ;
                READ:     if (last_capture) state_nx = ACK;
                ACK:      state_nx = (remaining_after == '0) ? DONE : WAIT_REQ;
                DONE:     state_nx = DONE;
                default:  state_nx = IDLE;
            endcase
        end
    end

    // Handshake and memory-port outputs decoded from the state.
    always_comb begin
        mem_ack_b           = (state != ACK);
        done_reading_memory = (state == DONE);
        imem_ceb            = !issue;
        imem_addr           = issue ? (base_addr + {11'b0, rd_idx}) : '0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Fetch bookkeeping, word capture and stream accounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining              <= '0;
            base_addr              <= '0;
            cnt                    <= '0;
            n_reads                <= '0;
            rd_idx                 <= '0;
            cap_pending            <= 1'b0;
            cap_lane               <= '0;
            fetch_mask             <= '0;
            instruction_word       <= '0;
            instruction_byte_valid <= '0;
        end else if (start) begin
            remaining   <= expectedBytes;
            base_addr   <= '0;
            rd_idx      <= '0;
            cap_pending <= 1'b0;
        end else begin
            case (state)
                WAIT_REQ: begin
                    if (!mem_req_b) begin
                        cnt         <= req_cnt;
                        n_reads     <= req_n;
                        rd_idx      <= '0;
                        cap_pending <= 1'b0;
                        fetch_mask  <= ~(16'hFFFF >> req_cnt);
                    end
                end
                READ: begin
                    if (issue) begin
                        rd_idx      <= rd_idx + 3'd1;
                        cap_pending <= 1'b1;
                        cap_lane    <= rd_idx[1:0];
                    end else begin
                        cap_pending <= 1'b0;
                    end
                    // Lane 0 capture also clears the lanes this fetch may not read.
                    if (cap_pending) begin
                        if (cap_lane == 2'd0) instruction_word <= {cap_data, 96'b0};
                        else                  instruction_word[lane_hi -: 32] <= cap_data;
                    end
                    if (last_capture) instruction_byte_valid <= fetch_mask;
                end
                ACK: begin
                    remaining <= remaining_after;
                    base_addr <= base_addr + {11'b0, n_reads};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bits_imem_reader.sv
// Self-checking bench for bits_imem_reader: directed scenarios plus random
// packet streams compared against a byte-level reference model.
module tb_bits_imem_reader;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [15:0]  expectedBytes;
    logic         mem_req_b;
    logic         mem_ack_b;
    logic [127:0] instruction_word;
    logic [15:0]  instruction_byte_valid;
    logic         done_reading_memory;
    logic         imem_ceb;
    logic [13:0]  imem_addr;
    logic [31:0]  imem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] mem [0:16383];

    typedef struct {
        int          c;
        logic [13:0] a;
    } rd_t;
    rd_t reads[$];

    bits_imem_reader dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .expectedBytes          (expectedBytes),
        .mem_req_b              (mem_req_b),
        .mem_ack_b              (mem_ack_b),
        .instruction_word       (instruction_word),
        .instruction_byte_valid (instruction_byte_valid),
        .done_reading_memory    (done_reading_memory),
        .imem_ceb               (imem_ceb),
        .imem_addr              (imem_addr),
        .imem_rdata             (imem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory: data one cycle after the enable.
    always @(posedge clk) if (!imem_ceb) imem_rdata <= mem[imem_addr];

    // Log every read with the cycle it was issued in.
    always @(negedge clk) begin
        rd_t r;
        if (!imem_ceb) begin
            r.c = cyc;
            r.a = imem_addr;
            reads.push_back(r);
        end
    end

    // Reference: bytes of a fetch taken from consecutive words at waddr.
    function automatic logic [127:0] model_word(int waddr, int n);
        logic [127:0] w;
        logic [31:0]  m;
        w = '0;
        for (int b = 0; b < n; b++) begin
            m = mem[(waddr + b / 4) % 16384];
            w[127 - 8*b -: 8] = m[31 - 8*(b % 4) -: 8];
        end
        return w;
    endfunction

    function automatic logic [15:0] model_valid(int n);
        logic [15:0] v;
        v = '0;
        for (int b = 0; b < n; b++) v[15 - b] = 1'b1;
        return v;
    endfunction

    task automatic do_start(input logic [15:0] e);
        start = 1'b1;
        expectedBytes = e;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One request: pulse mem_req_b, wait (bounded) for the ack.
    task automatic run_fetch(output int t0, output int lat, output logic [127:0] w,
                             output logic [15:0] v, output bit ok);
        reads.delete();
        t0 = cyc;
        ok = 1'b0;
        lat = -1;
        w = '0;
        v = '0;
        mem_req_b = 1'b0;
        @(negedge clk);
        mem_req_b = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (mem_ack_b == 1'b0) begin
                ok = 1'b1;
                lat = cyc - t0;
                w = instruction_word;
                v = instruction_byte_valid;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        expectedBytes = '0;
        mem_req_b = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (mem_ack_b !== 1'b1) begin errors++; $display("FAIL reset_ack got %b want 1", mem_ack_b); end
        checks++; if (imem_ceb !== 1'b1) begin errors++; $display("FAIL reset_ceb got %b want 1", imem_ceb); end
        checks++; if (imem_addr !== 14'd0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr); end
        checks++; if (instruction_word !== 128'd0) begin errors++; $display("FAIL reset_word got %h want 0", instruction_word); end
        checks++; if (instruction_byte_valid !== 16'd0) begin errors++; $display("FAIL reset_valid got %h want 0", instruction_byte_valid); end
        checks++; if (done_reading_memory !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_reading_memory); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_fetch;
        int t0, lat;
        logic [127:0] w;
        logic [15:0] v;
        bit ok;
        do_start(16'd16);
        run_fetch(t0, lat, w, v, ok);
        checks++; if (!ok || lat != 6) begin errors++; $display("FAIL full_latency got %0d want 6", lat); end
        checks++; if (reads.size() != 4) begin errors++; $display("FAIL full_nreads got %0d want 4", reads.size()); end
        for (int k = 0; k < reads.size() && k < 4; k++) begin
            checks++;
            if (reads[k].a !== 14'(k) || reads[k].c != t0 + 1 + k) begin
                errors++;
                $display("FAIL full_read%0d got addr %0d cyc %0d want addr %0d cyc %0d", k, reads[k].a, reads[k].c - t0, k, 1 + k);
            end
        end
        checks++; if (w !== 128'h38006F4529124000DEADBEEF01020304) begin errors++; $display("FAIL full_word got %h want 38006f4529124000deadbeef01020304", w); end
        checks++; if (v !== 16'hFFFF) begin errors++; $display("FAIL full_valid got %h want ffff", v); end
        @(negedge clk);
        checks++; if (mem_ack_b !== 1'b1) begin errors++; $display("FAIL full_ack_width got %b want 1", mem_ack_b); end
        checks++; if (done_reading_memory !== 1'b1) begin errors++; $display("FAIL full_done got %b want 1", done_reading_memory); end
        checks++; if (instruction_word !== 128'h38006F4529124000DEADBEEF01020304) begin errors++; $display("FAIL full_word_hold got %h", instruction_word); end
    endtask

    task automatic test_partial;
        int t0, lat;
        logic [127:0] w;
        logic [15:0] v;
        bit ok;
        do_start(16'd22);
        run_fetch(t0, lat, w, v, ok);
        checks++; if (!ok || v !== 16'hFFFF) begin errors++; $display("FAIL part_first_valid got %h want ffff", v); end
        @(negedge clk);
        run_fetch(t0, lat, w, v, ok);
        checks++; if (!ok || lat != 4) begin errors++; $display("FAIL part_latency got %0d want 4", lat); end
        checks++;
        if (reads.size() != 2 || reads[0].a !== 14'd4 || reads[1].a !== 14'd5) begin
            errors++;
            $display("FAIL part_reads got %0d reads want addr 4,5", reads.size());
        end
        checks++; if (v !== 16'hFC00) begin errors++; $display("FAIL part_valid got %h want fc00", v); end
        checks++; if (w[79:0] !== 80'd0) begin errors++; $display("FAIL part_tail got %h want 0", w[79:0]); end
        checks++; if (w !== model_word(4, 6)) begin errors++; $display("FAIL part_word got %h want %h", w, model_word(4, 6)); end
        @(negedge clk);
        checks++; if (done_reading_memory !== 1'b1) begin errors++; $display("FAIL part_done got %b want 1", done_reading_memory); end
    endtask

    task automatic test_zero_length;
        int acks, rds;
        do_start(16'd0);
        checks++; if (done_reading_memory !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", done_reading_memory); end
        acks = 0;
        rds = 0;
        mem_req_b = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (!mem_ack_b) acks++;
            if (!imem_ceb) rds++;
        end
        mem_req_b = 1'b1;
        checks++; if (acks != 0 || rds != 0) begin errors++; $display("FAIL zero_activity got %0d acks %0d reads want 0", acks, rds); end
    endtask

    task automatic test_reset_mid_read;
        int acks;
        do_start(16'd16);
        mem_req_b = 1'b0;
        @(negedge clk);        // first READ cycle
        mem_req_b = 1'b1;
        @(negedge clk);        // second READ cycle
        checks++; if (imem_ceb !== 1'b0) begin errors++; $display("FAIL rst_mid_reading got ceb %b want 0", imem_ceb); end
        reset = 1'b1;
        start = 1'b1;          // reset must win over start
        expectedBytes = 16'd16;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        checks++;
        if (mem_ack_b !== 1'b1 || imem_ceb !== 1'b1 || imem_addr !== 14'd0 || instruction_word !== 128'd0
            || instruction_byte_valid !== 16'd0 || done_reading_memory !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs got ack %b ceb %b addr %h valid %h done %b want reset values",
                     mem_ack_b, imem_ceb, imem_addr, instruction_byte_valid, done_reading_memory);
        end
        acks = 0;
        repeat (12) begin
            @(negedge clk);
            if (!mem_ack_b) acks++;
        end
        checks++; if (acks != 0) begin errors++; $display("FAIL rst_mid_no_ack got %0d acks want 0", acks); end
    endtask

    task automatic test_restart;
        int t0, lat;
        logic [127:0] w;
        logic [15:0] v;
        bit ok;
        do_start(16'd40);
        run_fetch(t0, lat, w, v, ok);
        @(negedge clk);
        do_start(16'd8);
        run_fetch(t0, lat, w, v, ok);
        checks++; if (reads.size() < 1 || reads[0].a !== 14'd0) begin errors++; $display("FAIL restart_addr got %0d reads want first at 0", reads.size()); end
        checks++; if (!ok || v !== 16'hFF00) begin errors++; $display("FAIL restart_valid got %h want ff00", v); end
        checks++; if (w !== model_word(0, 8)) begin errors++; $display("FAIL restart_word got %h want %h", w, model_word(0, 8)); end
        @(negedge clk);
        checks++; if (done_reading_memory !== 1'b1) begin errors++; $display("FAIL restart_done got %b want 1", done_reading_memory); end
        do_start(16'd16);
        checks++; if (done_reading_memory !== 1'b0) begin errors++; $display("FAIL restart_done_clear got %b want 0", done_reading_memory); end
    endtask

    task automatic test_back_to_back;
        int s, rds;
        int ack_c[$];
        s = cyc;
        start = 1'b1;
        expectedBytes = 16'd32;
        mem_req_b = 1'b0;
        @(negedge clk);
        start = 1'b0;
        rds = 0;
        repeat (30) begin
            if (!mem_ack_b) ack_c.push_back(cyc);
            if (!imem_ceb) rds++;
            @(negedge clk);
        end
        checks++; if (ack_c.size() != 2) begin errors++; $display("FAIL b2b_acks got %0d want 2", ack_c.size()); end
        checks++;
        if (ack_c.size() >= 2 && (ack_c[0] != s + 7 || ack_c[1] != ack_c[0] + 7)) begin
            errors++;
            $display("FAIL b2b_timing got %0d,%0d want %0d,%0d", ack_c[0] - s, ack_c[1] - s, 7, 14);
        end
        checks++; if (rds != 8) begin errors++; $display("FAIL b2b_reads got %0d want 8", rds); end
        checks++; if (done_reading_memory !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", done_reading_memory); end
        mem_req_b = 1'b1;
    endtask

    task automatic test_random_streams;
        int t0, lat, rem, waddr, n, nw, e;
        logic [127:0] w;
        logic [15:0] v;
        bit ok;
        for (int s = 0; s < 12; s++) begin
            e = $urandom_range(80, 1);
            do_start(16'(e));
            rem = e;
            waddr = 0;
            while (rem > 0) begin
                repeat ($urandom_range(3, 0)) @(negedge clk);
                n = (rem < 16) ? rem : 16;
                nw = (n + 3) / 4;
                run_fetch(t0, lat, w, v, ok);
                checks++; if (!ok || lat != nw + 2) begin errors++; $display("FAIL rnd_latency got %0d want %0d", lat, nw + 2); end
                checks++; if (reads.size() != nw || reads[0].a !== 14'(waddr)) begin errors++; $display("FAIL rnd_reads got %0d want %0d from %0d", reads.size(), nw, waddr); end
                checks++; if (w !== model_word(waddr, n)) begin errors++; $display("FAIL rnd_word got %h want %h", w, model_word(waddr, n)); end
                checks++; if (v !== model_valid(n)) begin errors++; $display("FAIL rnd_valid got %h want %h", v, model_valid(n)); end
                rem -= n;
                waddr += nw;
                @(negedge clk);
                checks++; if (done_reading_memory !== (rem == 0)) begin errors++; $display("FAIL rnd_done got %b want %b", done_reading_memory, rem == 0); end
                if (!ok) rem = 0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[0] = 32'h38006F45;
        mem[1] = 32'h29124000;
        mem[2] = 32'hDEADBEEF;
        mem[3] = 32'h01020304;
        @(negedge clk);
        test_reset;
        test_full_fetch;
        test_partial;
        test_zero_length;
        test_reset_mid_read;
        test_restart;
        test_back_to_back;
        test_random_streams;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
